axist_patgen_multi: RTL

Multi-mode, parametrised AXI4-Stream pattern generator for the AXIST full examples. It produces incrementing, decrementing, walking-one or PRBS data on a valid/ready stream, in either fixed-length bursts or continuous runs. It replaces the fixed 40-bit increment generator on the leader-side traffic source and feeds the AXIST transmit path or checker FIFO directly.

---
 rtl/axist_patgen_multi.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axist_patgen_multi.sv
// rtl/axist_patgen_multi.sv - multi-mode AXI4-Stream pattern generator (INCR/DECR/WALK1/PRBS, burst or continuous)
module axist_patgen_multi #(
    parameter int DATA_WIDTH = 40,
    parameter int CNT_WIDTH  = 9,
    parameter logic [DATA_WIDTH-1:0] PRBS_POLY = 40'hA0_0014_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  cont_en,
    input  logic [1:0]            mode_in,
    input  logic [DATA_WIDTH-1:0] seed_in,
    input  logic [7:0]            step_in,
    input  logic [CNT_WIDTH-1:0]  beat_cnt_in,
    input  logic                  tready_in,
    output logic                  tvalid_out,
    output logic [DATA_WIDTH-1:0] tdata_out,
    output logic                  tlast_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [CNT_WIDTH-1:0]  sent_cnt_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_INCR = 2'b00;
    localparam logic [1:0] M_DECR = 2'b01;
    localparam logic [1:0] M_WALK = 2'b10;

    logic [1:0]            state;
    logic [1:0]            mode_q;
    logic [7:0]            step_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  sent_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cont_q;
    logic                  stop_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  en_r1;
    logic                  en_r2;

    logic                  cont_rise;
    logic                  cont_fall;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] seed_norm;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CNT_WIDTH-1:0]  sent_inc;

    // Edges come from the registered copy so a continuous start lands two cycles after cont_en rises.
    assign cont_rise = en_r1 & ~en_r2;
    assign cont_fall = ~en_r1 & en_r2;
    assign xfer      = valid_q & tready_in;
    assign sent_inc  = sent_q + CNT_WIDTH'(1);

    always_comb begin
        seed_norm = seed_in;
        if (mode_in[1] && (seed_in == '0)) begin
            seed_norm = DATA_WIDTH'(1);
        end
    end

    always_comb begin
        data_next = data_q;
        case (mode_q)
            M_INCR:  data_next = data_q + DATA_WIDTH'(step_q);
            M_DECR:  data_next = data_q - DATA_WIDTH'(step_q);
            M_WALK:  data_next = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
            default: data_next = {data_q[DATA_WIDTH-2:0], ^(data_q & PRBS_POLY)};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mode_q  <= 2'b00;
            step_q  <= 8'd0;
            cnt_q   <= '0;
            sent_q  <= '0;
            data_q  <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_r1   <= 1'b0;
            en_r2   <= 1'b0;
        end else begin
            en_r1  <= cont_en;
            en_r2  <= en_r1;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cont_rise || start_in) begin
                        mode_q <= mode_in;
                        step_q <= step_in;
                        cnt_q  <= beat_cnt_in;
                        cont_q <= cont_rise;
                        stop_q <= 1'b0;
                        data_q <= seed_norm;
                        sent_q <= '0;
                        busy_q <= 1'b1;
                        if (!cont_rise && (beat_cnt_in == '0)) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            valid_q <= 1'b1;
                            last_q  <= !cont_rise && (beat_cnt_in == CNT_WIDTH'(1));
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        data_q <= data_next;
                        sent_q <= sent_inc;
                    end
                    if (cont_q) begin
                        if (cont_fall) begin
                            stop_q <= 1'b1;
                        end
                        // A pending beat is never withdrawn: stop only once it has been accepted.
                        if ((stop_q || cont_fall) && (!valid_q || xfer)) begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if (xfer) begin
                        if (last_q) begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            last_q <= (sent_inc == (cnt_q - CNT_WIDTH'(1)));
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign tvalid_out   = valid_q;
    assign tdata_out    = data_q;
    assign tlast_out    = last_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign sent_cnt_out = sent_q;

endmodule
